clk_step_gen: RTL and testbench
===============================

// Module: clk_step_gen
// PURPOSE
//  Parametrised board clock/step source for the lab latch/FF experiments: free-running divider
//  with runtime-selectable tap, debounced single-step from a push button, optional N-step burst.
//  Drives a level clock (ck) plus a one-cycle clock-enable (ck_en) for downstream logic on clk.
// PARAMETERS
//  CNT_W      32   divider counter width
//  TAP_W      5    width of tap_sel (2**TAP_W >= CNT_W)
//  DB_CYCLES  1_000_000  consecutive stable samples to accept a button change (10 ms @100 MHz)
//  DB_W       20   debounce counter width (2**DB_W >= DB_CYCLES)
//  BURST_W    8    burst length width
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        asynchronous reset, active low
//  mode       in   2        00 FREE, 01 STEP, 10 BURST, 11 HOLD
//  tap_sel    in   TAP_W    divider bit driving ck in FREE/BURST
//  pulse      in   1        raw push button, active high, asynchronous
//  burst_len  in   BURST_W  steps per burst
//  clkdiv     out  CNT_W    free-running divider count
//  ck         out  1        registered output clock level
//  ck_en      out  1        one-cycle strobe coincident with each ck rise
//  busy       out  1        burst in progress
// BEHAVIOUR
//  Reset: clkdiv=0, ck=0, ck_en=0, busy=0, sync FFs=0, debounced level=0, counters=0.
//  clkdiv: +1 every clk, wraps 2**CNT_W-1 -> 0; runs in all modes.
//  Tap: t = clkdiv[min(tap_sel, CNT_W-1)]; tap_q registers t; tap_rise = t & ~tap_q.
//  Button: 2-FF synchroniser; db_cnt clears when sync==db_lvl, else increments; at
//   db_cnt==DB_CYCLES-1 db_lvl<=sync, db_cnt<=0. press = one-cycle db_lvl 0->1 edge.
//  FREE: ck<=t (1 cycle latency from clkdiv); ck_en<=tap_rise.
//  STEP: ck<=db_lvl; ck_en<=press; exactly one strobe per accepted press.
//  BURST: idle + press + burst_len!=0 -> rem<=burst_len, busy<=1; press with burst_len==0 ignored.
//   busy: ck<=t, ck_en<=tap_rise, each tap_rise decrements rem; on the rise taking rem to 0,
//   busy<=0 next cycle; idle: ck<=0, ck_en<=0. Press while busy ignored.
//  HOLD: ck<=0, ck_en<=0.
//  Mode change: effective next clk; aborts burst (rem<=0, busy<=0); no ck_en from the switch
//   itself (tap_q and db_lvl track in every mode, so edges never accumulate).
//  tap_sel change mid-run: new tap used next cycle; ck_en only on genuine 0->1 of new tap.
//  ck_en never high two consecutive cycles; ck_en=1 implies ck=1 same cycle.
//  Reset mid-burst/mid-debounce: all state to reset values immediately.
// CONFIGURATION
//  CLK_STEP_BURST_EN defined: BURST mode as above.
//  Not defined: mode 10 behaves as HOLD, rem logic removed, busy tied 0, burst_len unused.
// STRUCTURE
//  Package clk_step_pkg: MODE_FREE/STEP/BURST/HOLD 2-bit localparams, default widths.
//  Sub-module btn_debounce (synchroniser + debounce counter + rise strobe; params DB_CYCLES,
//   DB_W; ports clk, rst_n, btn_in, level, rise).
// TESTING (sim with DB_CYCLES=4, CNT_W=8)
//  FREE tap_sel=2 -> ck period 8 clk, ck_en every 8 clk, first ck_en when clkdiv 3->4 +1 cycle.
//  STEP: 3-cycle glitch on pulse -> no strobe; 10-cycle hold -> exactly one ck_en, ck high.
//  BURST burst_len=3, tap_sel=1, press -> 3 ck_en 4 clk apart, busy low after 3rd; ck idle 0.
//  BURST press while busy / burst_len=0 -> rem unchanged / no busy, no strobes.
//  Mode FREE->HOLD->FREE and tap_sel=7->0 mid-run -> no spurious ck_en; rst_n low mid-burst ->
//   busy=0, ck=0, clkdiv=0 same cycle.
//  tap_sel=31 -> behaves as tap 7 (clamp); counter wraps 255->0 without extra strobe.

Source files
------------

// File: rtl/clk_step_pkg.sv
// -----------------------------------------------------------------------------
// clk_step_pkg
// Shared definitions for the clk_step_gen lab clock/step source:
//   - MODE_* : 2-bit encodings of the mode input
//   - DEF_*  : default parameter values (production widths, 100 MHz debounce)
//   - burst_state_t : burst sequencer states
// -----------------------------------------------------------------------------
package clk_step_pkg;

    localparam logic [1:0] MODE_FREE  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    localparam int unsigned DEF_CNT_W     = 32;
    localparam int unsigned DEF_TAP_W     = 5;
    localparam int unsigned DEF_DB_CYCLES = 1_000_000;
    localparam int unsigned DEF_DB_W      = 20;
    localparam int unsigned DEF_BURST_W   = 8;

    typedef enum logic {
        BURST_IDLE = 1'b0,
        BURST_RUN  = 1'b1
    } burst_state_t;

endpackage

// File: rtl/clk_step_gen_if.sv
// -----------------------------------------------------------------------------
// clk_step_gen_if
// Control/status bundle of clk_step_gen.
//   Controls (master -> slave): mode[1:0], tap_sel[TAP_W], pulse, burst_len[BURST_W]
//   Status   (slave -> master): clkdiv[CNT_W], ck, ck_en, busy
// modport master : the side that drives the controls (board glue / testbench)
// modport slave  : clk_step_gen itself
// -----------------------------------------------------------------------------
interface clk_step_gen_if
    import clk_step_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TAP_W   = DEF_TAP_W,
    parameter int unsigned BURST_W = DEF_BURST_W
) ();

    logic [1:0]         mode;
    logic [TAP_W-1:0]   tap_sel;
    logic               pulse;
    logic [BURST_W-1:0] burst_len;

    logic [CNT_W-1:0]   clkdiv;
    logic               ck;
    logic               ck_en;
    logic               busy;

    modport master (
        output mode, tap_sel, pulse, burst_len,
        input  clkdiv, ck, ck_en, busy
    );

    modport slave (
        input  mode, tap_sel, pulse, burst_len,
        output clkdiv, ck, ck_en, busy
    );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a stability counter for a raw push button.
// A change of the synchronised input is accepted only after DB_CYCLES
// consecutive samples that disagree with the current debounced level.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous reset, active low
//   btn_in in   raw button, asynchronous to clk
//   level  out  debounced button level
//   rise   out  one-cycle strobe, high in the first cycle level reads 1
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned DB_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic level,
    output logic rise
);

    logic [1:0]      sync_q;
    logic [DB_W-1:0] cnt_q;
    logic            level_q;
    logic            rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_in};
            rise_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
                // Rise is registered alongside the level update so the
                // strobe lines up with the first cycle of the new level.
                level_q <= sync_q[1];
                rise_q  <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/clk_step_gen.sv
// -----------------------------------------------------------------------------
// clk_step_gen
// Board clock/step source for the latch/FF experiments. A free-running divider
// feeds a runtime-selected tap; a debounced push button gives single steps; an
// optional burst mode emits burst_len steps per press. Produces a registered
// level clock (ck) and a one-cycle enable (ck_en) coincident with each ck rise.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous reset, active low
//   bus    slave modport of clk_step_gen_if:
//            mode      00 FREE, 01 STEP, 10 BURST, 11 HOLD
//            tap_sel   divider bit driving ck (clamped to CNT_W-1)
//            pulse     raw push button, active high
//            burst_len steps per burst
//            clkdiv    free-running divider count
//            ck        registered output clock level
//            ck_en     one-cycle strobe with each ck rise
//            busy      burst in progress
// Configuration macro: CLK_STEP_BURST_EN
//   defined   : BURST mode active
//   undefined : mode 10 acts as HOLD, busy tied low, burst_len ignored
// -----------------------------------------------------------------------------
module clk_step_gen
    import clk_step_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned TAP_W     = DEF_TAP_W,
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
    parameter int unsigned DB_W      = DEF_DB_W,
    parameter int unsigned BURST_W   = DEF_BURST_W
) (
    input  logic          clk,
    input  logic          rst_n,
    clk_step_gen_if.slave bus
);

    localparam int unsigned IDX_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    logic [CNT_W-1:0] clkdiv_q;
    logic [IDX_W-1:0] tap_idx;
    logic             tap_bit;
    logic             tap_q;
    logic             tap_rise;
    logic             db_level;
    logic             press;
    logic             ck_q, ck_d;
    logic             ck_en_q, ck_en_d;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_btn_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (bus.pulse),
        .level  (db_level),
        .rise   (press)
    );

    always_comb begin
        if (bus.tap_sel > TAP_W'(CNT_W - 1)) begin
            tap_idx = IDX_W'(CNT_W - 1);
        end else begin
            tap_idx = IDX_W'(bus.tap_sel);
        end
    end

    // tap_q follows the selected bit in every mode, so switching mode never
    // releases a stale edge as a strobe.
    assign tap_bit  = clkdiv_q[tap_idx];
    assign tap_rise = tap_bit & ~tap_q;

`ifdef CLK_STEP_BURST_EN
    burst_state_t       state_q, state_d;
    logic [BURST_W-1:0] rem_q, rem_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BURST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.busy = (state_q == BURST_RUN);
`else
    logic unused_burst_len;
    assign unused_burst_len = ^bus.burst_len;
    assign bus.busy         = 1'b0;
`endif

    always_comb begin
        ck_d    = 1'b0;
        ck_en_d = 1'b0;
`ifdef CLK_STEP_BURST_EN
        // Any mode other than BURST aborts a running burst.
        state_d = BURST_IDLE;
        rem_d   = '0;
`endif
        case (bus.mode)
            MODE_FREE: begin
                ck_d    = tap_bit;
                ck_en_d = tap_rise;
            end
            MODE_STEP: begin
                ck_d    = db_level;
                ck_en_d = press;
            end
`ifdef CLK_STEP_BURST_EN
            MODE_BURST: begin
                state_d = state_q;
                rem_d   = rem_q;
                if (state_q == BURST_RUN) begin
                    ck_d    = tap_bit;
                    ck_en_d = tap_rise;
                    if (tap_rise) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == BURST_W'(1)) begin
                            state_d = BURST_IDLE;
                        end
                    end
                end else if (press && (bus.burst_len != '0)) begin
                    rem_d   = bus.burst_len;
                    state_d = BURST_RUN;
                end
            end
`endif
            default: begin
                // HOLD: ck and ck_en stay low
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv_q <= '0;
            tap_q    <= 1'b0;
            ck_q     <= 1'b0;
            ck_en_q  <= 1'b0;
        end else begin
            clkdiv_q <= clkdiv_q + 1'b1;
            tap_q    <= tap_bit;
            ck_q     <= ck_d;
            ck_en_q  <= ck_en_d;
        end
    end

    assign bus.clkdiv = clkdiv_q;
    assign bus.ck     = ck_q;
    assign bus.ck_en  = ck_en_q;

endmodule

// File: tb/tb_clk_step_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_step_gen
// Directed scenarios followed by a randomized phase, checked every cycle against
// a behavioural model of the clock/step source kept in this file.
// -----------------------------------------------------------------------------
module tb_clk_step_gen;
    import clk_step_pkg::*;

    localparam int CNT_W     = 8;
    localparam int TAP_W     = 5;
    localparam int BURST_W   = 8;
    localparam int DB_CYCLES = 4;
    localparam int DB_W      = 3;
`ifdef CLK_STEP_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    clk_step_gen_if #(.CNT_W(CNT_W), .TAP_W(TAP_W), .BURST_W(BURST_W)) bus ();

    clk_step_gen #(
        .CNT_W     (CNT_W),
        .TAP_W     (TAP_W),
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W),
        .BURST_W   (BURST_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_count;   // cycles since reset, modulo 2**CNT_W
    int m_prev_t;  // selected divider bit one cycle ago
    int m_run;     // consecutive synchronised samples disagreeing with level
    bit m_level, m_press, m_h0, m_h1;
    bit m_ck, m_cken, m_busy;
    int m_rem;
    bit prev_cken_obs;

    // observation window
    int cyc;
    int win_strobes, win_last, win_gap, win_busy, win_last_div;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_prev_t = 0; m_run = 0;
        m_level = 0; m_press = 0; m_h0 = 0; m_h1 = 0;
        m_ck = 0; m_cken = 0; m_busy = 0; m_rem = 0;
        prev_cken_obs = 0;
    endtask

    task automatic begin_window(input int gap);
        win_strobes = 0; win_last = -1; win_gap = gap; win_busy = 0; win_last_div = -1;
    endtask

    task automatic tick();
        int tapi, t, eff;
        bit tr, n_ck, n_cken, n_press;
        tapi = (int'(bus.tap_sel) > CNT_W - 1) ? CNT_W - 1 : int'(bus.tap_sel);
        t    = (m_count >> tapi) & 1;
        tr   = (t == 1) && (m_prev_t == 0);
        eff  = int'(bus.mode);
        if (eff == 2 && !BURST_EN) eff = 3;
        n_ck = 0; n_cken = 0;
        if (eff == 0) begin
            n_ck = t[0]; n_cken = tr;
        end else if (eff == 1) begin
            n_ck = m_level; n_cken = m_press;
        end else if (eff == 2) begin
            if (m_busy) begin
                n_ck = t[0]; n_cken = tr;
                if (tr) begin
                    m_rem--;
                    if (m_rem == 0) m_busy = 0;
                end
            end else if (m_press && bus.burst_len != 0) begin
                m_rem  = int'(bus.burst_len);
                m_busy = 1;
            end
        end
        if (eff != 2) begin m_busy = 0; m_rem = 0; end
        // button: m_h1 is the pulse value sampled two edges earlier
        n_press = 0;
        if (m_h1 != m_level) begin
            m_run++;
            if (m_run == DB_CYCLES) begin
                m_level = m_h1; m_run = 0; n_press = m_h1;
            end
        end else begin
            m_run = 0;
        end
        m_press  = n_press;
        m_h1     = m_h0;
        m_h0     = bus.pulse;
        m_prev_t = t;
        m_count  = (m_count + 1) % (1 << CNT_W);
        m_ck     = n_ck;
        m_cken   = n_cken;

        @(posedge clk);
        #1;
        cyc++;
        check("clkdiv", bus.clkdiv, m_count);
        check("ck", bus.ck, m_ck);
        check("ck_en", bus.ck_en, m_cken);
        check("busy", bus.busy, m_busy);
        check("ck_en_implies_ck", bus.ck_en & ~bus.ck, 0);
        check("ck_en_back_to_back", bus.ck_en & prev_cken_obs, 0);
        prev_cken_obs = bus.ck_en;
        if (bus.ck_en === 1'b1) begin
            win_strobes++;
            if (win_gap > 0 && win_last >= 0) check("strobe_gap", cyc - win_last, win_gap);
            win_last     = cyc;
            win_last_div = int'(bus.clkdiv);
        end
        if (bus.busy === 1'b1) win_busy++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // called at posedge+1; checks outputs while reset is still asserted
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_clkdiv", bus.clkdiv, 0);
        check("rst_ck", bus.ck, 0);
        check("rst_ck_en", bus.ck_en, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        cyc = 0;
        begin_window(0);
        bus.mode = MODE_FREE; bus.tap_sel = 5'd2; bus.pulse = 1'b0; bus.burst_len = '0;
        #1;
        do_reset();

        // FREE, tap 2: period 8, first strobe after clkdiv reaches 4
        begin_window(8);
        ticks(40);
        check("free_strobes", win_strobes, 5);
        check("free_last_div", win_last_div, 37);

        // STEP: 3-cycle glitch rejected, 10-cycle hold gives one strobe
        bus.mode = MODE_STEP;
        begin_window(0);
        bus.pulse = 1'b1; ticks(3);
        bus.pulse = 1'b0; ticks(10);
        check("step_glitch_strobes", win_strobes, 0);
        begin_window(0);
        bus.pulse = 1'b1; ticks(10);
        bus.pulse = 1'b0; ticks(12);
        check("step_hold_strobes", win_strobes, 1);

        // BURST A: len 3, tap 1 -> three strobes 4 apart
        bus.mode = MODE_BURST; bus.tap_sel = 5'd1; bus.burst_len = 8'd3;
        begin_window(4);
        bus.pulse = 1'b1; ticks(10);
        bus.pulse = 1'b0; ticks(30);
        check("burstA_strobes", win_strobes, BURST_EN ? 3 : 0);
        check("burstA_busy_end", bus.busy, 0);

        // BURST B: len 2, tap 4, second press while busy is ignored
        bus.tap_sel = 5'd4; bus.burst_len = 8'd2;
        begin_window(32);
        bus.pulse = 1'b1; ticks(10);
        bus.pulse = 1'b0; ticks(10);
        bus.pulse = 1'b1; ticks(10);
        bus.pulse = 1'b0; ticks(90);
        check("burstB_strobes", win_strobes, BURST_EN ? 2 : 0);

        // BURST C: len 0 -> nothing happens
        bus.burst_len = 8'd0;
        begin_window(0);
        bus.pulse = 1'b1; ticks(10);
        bus.pulse = 1'b0; ticks(20);
        check("burstC_strobes", win_strobes, 0);
        check("burstC_busy_cycles", win_busy, 0);

        // reset in the middle of a burst
        bus.burst_len = 8'd3;
        bus.pulse = 1'b1; ticks(10);
        bus.pulse = 1'b0;
        check("busy_before_rst", bus.busy, BURST_EN);
        do_reset();

        // FREE -> HOLD -> FREE, then tap 7 -> 0 while running
        bus.mode = MODE_FREE; bus.tap_sel = 5'd7;
        begin_window(0);
        ticks(150);
        bus.mode = MODE_HOLD; ticks(20);
        bus.mode = MODE_FREE; ticks(20);
        bus.tap_sel = 5'd0; ticks(20);

        // tap 31 clamps to bit 7; wrap 255 -> 0 gives no extra strobe
        do_reset();
        bus.tap_sel = 5'd31;
        begin_window(0);
        ticks(300);
        check("tap31_strobes", win_strobes, 1);
        check("tap31_strobe_div", win_last_div, 129);

        // randomized mode/tap/button/burst activity
        begin_window(0);
        for (int seg = 0; seg < 100; seg++) begin
            bus.mode      = 2'($urandom_range(0, 3));
            bus.tap_sel   = 5'($urandom_range(0, 31));
            bus.burst_len = 8'($urandom_range(0, 5));
            for (int k = 0; k < int'($urandom_range(1, 30)); k++) begin
                if ($urandom_range(0, 7) == 0) bus.pulse = ~bus.pulse;
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
